// File: rtl/exe_result_fifo_if.sv
// Handshake bundle between exe_unit (producer), exe_result_fifo and the
// writeback consumer. Signal names are written from the FIFO's point of view.
// The FIFO uses the slave modport. The environment (ALU side plus consumer
// side) uses the master modport.
interface exe_result_fifo_if #(
    parameter int M = 4,
    parameter int N = 4
);
    // Producer side: ALU result tuple entering the FIFO
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_oper;
    logic [M-1:0] i_result;
    logic         i_BF0;
    logic         i_BF1;
    logic         i_PF;
    logic         i_NF;

    // Consumer side: oldest entry leaving the FIFO
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_oper;
    logic [M-1:0] o_result;
    logic [3:0]   o_flags;

    modport slave (
        input  i_valid, i_oper, i_result, i_BF0, i_BF1, i_PF, i_NF, i_ready,
        output o_ready, o_valid, o_oper, o_result, o_flags
    );

    modport master (
        output i_valid, i_oper, i_result, i_BF0, i_BF1, i_PF, i_NF, i_ready,
        input  o_ready, o_valid, o_oper, o_result, o_flags
    );
endinterface

// File: rtl/exe_result_fifo.sv
// exe_result_fifo: small result queue behind exe_unit.
// - Captures {oper, result, NF, PF, BF1, BF0} tuples on a valid/ready push port.
// - Presents the oldest tuple on a valid/ready pop port, one cycle after the
//   push edge. There is no bypass and no pass-through when the queue is full.
// - Keeps sticky flags: the OR of the flags of every accepted tuple, held until
//   i_clear_sticky is asserted.
// Optional feature: define EXE_FIFO_DROP_CNT_EN to get a saturating 8-bit
// counter of rejected pushes on o_drop_cnt. Without the define, o_drop_cnt is
// tied to zero and no counter flops are built.
module exe_result_fifo #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    exe_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [3:0]               o_sticky_flags,
    input  logic                     i_clear_sticky,
    output logic [7:0]               o_drop_cnt
);

    // Pointer index width. Each pointer carries one extra MSB, so "full" and
    // "empty" can be told apart by the plain difference of the two pointers.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [N-1:0] oper;
        logic [M-1:0] result;
        logic [3:0]   flags;   // {NF, PF, BF1, BF0}
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    sticky_q, sticky_d;

    logic [CW-1:0] count;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    in_flags;
    entry_t        head;

    // Occupancy and handshake qualification, all derived from the pointers
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        wr_idx   = wr_ptr_q[PW-1:0];
        rd_idx   = rd_ptr_q[PW-1:0];
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        // A full queue refuses a push even when a pop happens in the same cycle
        push     = bus.i_valid && !full;
        pop      = !empty && bus.i_ready;
        in_flags = {bus.i_NF, bus.i_PF, bus.i_BF1, bus.i_BF0};
    end

    // Head entry is forced to zero when nothing is stored
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_q[rd_idx];
        end
    end

    assign bus.o_ready    = !full;
    assign bus.o_valid    = !empty;
    assign bus.o_oper     = head.oper;
    assign bus.o_result   = head.result;
    assign bus.o_flags    = head.flags;
    assign o_count        = count;
    assign o_sticky_flags = sticky_q;

    // Next state for storage and pointers. Entries are written once and never
    // touched again, so the head stays stable while the consumer stalls.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_idx] = '{oper: bus.i_oper, result: bus.i_result, flags: in_flags};
            // Power-of-two depth: natural overflow wraps DEPTH-1 back to 0
            wr_ptr_d      = wr_ptr_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    // Sticky flags. When a clear and a push land in the same cycle, the new
    // entry's flags survive the clear.
    always_comb begin
        sticky_d = sticky_q;
        if (push) begin
            sticky_d = (i_clear_sticky ? 4'b0000 : sticky_q) | in_flags;
        end else if (i_clear_sticky) begin
            sticky_d = 4'b0000;
        end
    end

    // State registers. Reset empties the queue and wipes storage, so nothing
    // written before the reset can reappear afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sticky_q <= 4'b0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
            mem_q    <= mem_d;
        end
    end

`ifdef EXE_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Increment that holds at the all-ones value instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count every cycle in which the producer offers a tuple that is refused
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.i_valid && full) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    // Drop counter register. Only reset clears it; i_clear_sticky does not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_exe_result_fifo.sv
// Scoreboard bench for exe_result_fifo (M=4, N=4, DEPTH=4).
// The stimulus pushes each tuple it expects to be accepted into exp_q. The
// monitor pops exp_q and compares on every pop handshake. Occupancy, ready,
// sticky and drop counter are checked directly by the stimulus thread.
module tb_exe_result_fifo;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] oper;
        logic [3:0] result;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] count;
    logic [3:0] sticky;
    logic [7:0] drop;

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    exe_result_fifo_if #(.M(M), .N(N)) bus ();

    exe_result_fifo #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_count        (count),
        .o_sticky_flags (sticky),
        .i_clear_sticky (clear),
        .o_drop_cnt     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop handshake must match the oldest expected tuple
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: actual result %0h required no entry", bus.o_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_oper", 32'(bus.o_oper), 32'(e.oper));
                chk("pop_result", 32'(bus.o_result), 32'(e.result));
                chk("pop_flags", 32'(bus.o_flags), 32'(e.flags));
            end
        end
    end

    // One clock of stimulus; flags f are {NF,PF,BF1,BF0}
    task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] res,
                       input logic [3:0] f, input logic rdy, input logic clr);
        bus.i_valid  = v;
        bus.i_oper   = op;
        bus.i_result = res;
        {bus.i_NF, bus.i_PF, bus.i_BF1, bus.i_BF0} = f;
        bus.i_ready  = rdy;
        clear        = clr;
        @(posedge clk);
        #1;
    endtask

    // Push that is expected to be accepted
    task automatic push(input logic [3:0] op, input logic [3:0] res,
                        input logic [3:0] f, input logic rdy, input logic clr);
        exp_t e;
        e.oper = op; e.result = res; e.flags = f;
        exp_q.push_back(e);
        cyc(1'b1, op, res, f, rdy, clr);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, rdy, 1'b0);
    endtask

    // Hard bound on the whole run
    initial begin
        #100000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int seed;
        logic [31:0] r;
        n_checks = 0;
        n_fail   = 0;
        seed     = 1;
        rst_n    = 1'b0;
        bus.i_valid = 1'b0; bus.i_oper = '0; bus.i_result = '0;
        bus.i_BF0 = 1'b0; bus.i_BF1 = 1'b0; bus.i_PF = 1'b0; bus.i_NF = 1'b0;
        bus.i_ready = 1'b0; clear = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_ready", 32'(bus.o_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_result", 32'(bus.o_result), 0);
        rst_n = 1'b1;
        idle(1'b0);

        // Order and latency with the consumer stalled
        push(4'd9, 4'd5, 4'b0100, 1'b0, 1'b0);
        chk("lat_valid", 32'(bus.o_valid), 1);
        chk("lat_result", 32'(bus.o_result), 5);
        chk("lat_flags", 32'(bus.o_flags), 32'b0100);
        push(4'd9, 4'd12, 4'b1001, 1'b0, 1'b0);
        push(4'd0, 4'd0, 4'b0011, 1'b0, 1'b0);
        chk("ord_count3", 32'(count), 3);
        chk("ord_head_stable", 32'(bus.o_result), 5);
        chk("ord_sticky", 32'(sticky), 32'b1111);
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("ord_empty_valid", 32'(bus.o_valid), 0);
        chk("ord_empty_count", 32'(count), 0);
        chk("ord_empty_result", 32'(bus.o_result), 0);
        chk("ord_empty_flags", 32'(bus.o_flags), 0);

        // Asynchronous reset mid-stream with three entries stored
        push(4'd1, 4'd1, 4'b0010, 1'b0, 1'b0);
        push(4'd2, 4'd2, 4'b0010, 1'b0, 1'b0);
        push(4'd3, 4'd3, 4'b0010, 1'b0, 1'b0);
        chk("mid_count3", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.o_valid), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_ready", 32'(bus.o_ready), 1);
        chk("mid_rst_sticky", 32'(sticky), 0);
        chk("mid_rst_drop", 32'(drop), 0);
        exp_q.delete();
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b1);
        chk("post_rst_valid", 32'(bus.o_valid), 0);

        // Full, rejected push during a pop, pointer wrap
        push(4'd1, 4'd1, 4'b0000, 1'b0, 1'b0);
        push(4'd2, 4'd2, 4'b0000, 1'b0, 1'b0);
        push(4'd3, 4'd3, 4'b0000, 1'b0, 1'b0);
        push(4'd4, 4'd4, 4'b0000, 1'b0, 1'b0);
        chk("full_ready", 32'(bus.o_ready), 0);
        chk("full_count", 32'(count), 4);
        cyc(1'b1, 4'd7, 4'd7, 4'b0000, 1'b1, 1'b0);
        chk("rej_count", 32'(count), 3);
        chk("rej_head", 32'(bus.o_result), 2);
        push(4'd5, 4'd5, 4'b0000, 1'b1, 1'b0);
        push(4'd6, 4'd6, 4'b0000, 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 4);
`ifdef EXE_FIFO_DROP_CNT_EN
        chk("wrap_drop", 32'(drop), 1);
`else
        chk("wrap_drop", 32'(drop), 0);
`endif
        repeat (4) idle(1'b1);
        chk("wrap_drained", 32'(count), 0);

        // Simultaneous push and pop at count 2
        push(4'd10, 4'd10, 4'b0001, 1'b0, 1'b0);
        push(4'd11, 4'd11, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            r = $random(seed);
            push(r[3:0], r[7:4], r[11:8], 1'b1, 1'b0);
            chk("pp_count", 32'(count), 2);
        end
        idle(1'b1); idle(1'b1);
        chk("pp_drained", 32'(count), 0);

        // Sticky flags
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("stk_clear0", 32'(sticky), 0);
        push(4'd1, 4'd1, 4'b0001, 1'b0, 1'b0);
        push(4'd2, 4'd2, 4'b0100, 1'b0, 1'b0);
        chk("stk_or", 32'(sticky), 32'b0101);
        push(4'd3, 4'd3, 4'b1000, 1'b0, 1'b1);
        chk("stk_clr_push", 32'(sticky), 32'b1000);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("stk_clr_alone", 32'(sticky), 0);
        repeat (3) idle(1'b1);

        // Rejected pushes against a full, stalled queue
        push(4'd8,  4'd8,  4'b0001, 1'b0, 1'b0);
        push(4'd9,  4'd9,  4'b0010, 1'b0, 1'b0);
        push(4'd10, 4'd10, 4'b0100, 1'b0, 1'b0);
        push(4'd11, 4'd11, 4'b1000, 1'b0, 1'b0);
        repeat (300) cyc(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
`ifdef EXE_FIFO_DROP_CNT_EN
        chk("sat_drop", 32'(drop), 32'hFF);
`else
        chk("sat_drop", 32'(drop), 0);
`endif
        chk("sat_count", 32'(count), 4);
        chk("sat_head", 32'(bus.o_result), 8);
        repeat (4) idle(1'b1);
        chk("sat_drained", 32'(count), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
